load_store_unit: RTL and testbench

- Sits directly upstream of the CPU data memory, between the datapath's memory stage and the word-addressed, single-port RAM.
- Accepts byte-addressed load/store requests of byte, halfword or word size over a valid/ready handshake.
- Drives word address, write data and write enable to the RAM, and sign- or zero-extends load data.
- Implements sub-word stores as read-modify-write and flags misaligned or illegal-size requests.

---
 rtl/lsu_pkg.sv | 32 +++
 rtl/lsu_lane_align.sv | 39 +++
 rtl/load_store_unit.sv | 123 ++++++++++++
 tb/tb_load_store_unit.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// Shared encodings for the load/store unit: access sizes, FSM states, lane widths
// and the alignment rule that decides whether a request is rejected.
package lsu_pkg;

    localparam int BYTE_W = 8;
    localparam int HALF_W = 16;
    localparam int WORD_W = 32;

    typedef enum logic [1:0] {
        SIZE_BYTE    = 2'b00,
        SIZE_HALF    = 2'b01,
        SIZE_WORD    = 2'b10,
        SIZE_ILLEGAL = 2'b11
    } size_e;

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        MERGE,
        RESP
    } state_e;

    function automatic logic req_error(input size_e size, input logic [1:0] lane);
        case (size)
            SIZE_HALF:    return lane[0];
            SIZE_WORD:    return lane != 2'b00;
            SIZE_ILLEGAL: return 1'b1;
            default:      return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Combinational lane steering: extracts and extends a load lane from a RAM word,
// and builds the read-modify-write word for sub-word stores. Zero latency, no handshake.
module lsu_lane_align
    import lsu_pkg::*;
(
    input  logic [WORD_W-1:0] word,
    input  logic [1:0]        lane,
    input  size_e             size,
    input  logic              is_signed,
    input  logic [HALF_W-1:0] store_data,
    output logic [WORD_W-1:0] load_value,
    output logic [WORD_W-1:0] merged_word
);

    logic [BYTE_W-1:0] byte_sel;
    logic [HALF_W-1:0] half_sel;

    // Halfwords are always 2-byte aligned here, so only lane[1] picks the half.
    assign byte_sel = word[{lane, 3'b000} +: BYTE_W];
    assign half_sel = word[{lane[1], 4'b0000} +: HALF_W];

    always_comb begin
        load_value  = '0;
        merged_word = word;
        case (size)
            SIZE_BYTE: begin
                load_value = {{(WORD_W-BYTE_W){is_signed & byte_sel[BYTE_W-1]}}, byte_sel};
                merged_word[{lane, 3'b000} +: BYTE_W] = store_data[BYTE_W-1:0];
            end
            SIZE_HALF: begin
                load_value = {{(WORD_W-HALF_W){is_signed & half_sel[HALF_W-1]}}, half_sel};
                merged_word[{lane[1], 4'b0000} +: HALF_W] = store_data;
            end
            SIZE_WORD: load_value = word;
            default: ;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Byte-addressed load/store front end for a word RAM; load/word store respond 2 cycles after accept,
// sub-word store (read-modify-write) 3, errors 1. One request in flight; RESP holds until RespReady.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int ADDRESS_WIDTH = 16,
    parameter int DATA_WIDTH    = 32
) (
    input  logic                     Clk,
    input  logic                     Rst_n,
    input  logic                     ReqValid,
    output logic                     ReqReady,
    input  logic [ADDRESS_WIDTH+1:0] ReqAddr,
    input  logic                     ReqWrite,
    input  logic [1:0]               ReqSize,
    input  logic                     ReqSigned,
    input  logic [DATA_WIDTH-1:0]    ReqWData,
    output logic                     RespValid,
    input  logic                     RespReady,
    output logic [DATA_WIDTH-1:0]    RespRData,
    output logic                     RespErr,
    output logic [ADDRESS_WIDTH-1:0] MemAddress,
    output logic [DATA_WIDTH-1:0]    MemWriteData,
    output logic                     MemWrite,
    input  logic [DATA_WIDTH-1:0]    MemData
);

    state_e            state;
    logic [1:0]        lat_lane;
    logic              lat_write;
    size_e             lat_size;
    logic              lat_signed;
    logic [HALF_W-1:0] lat_wdata;

    logic [DATA_WIDTH-1:0] load_value;
    logic [DATA_WIDTH-1:0] merged_word;

    assign ReqReady = (state == IDLE);

    lsu_lane_align u_align (
        .word        (MemData),
        .lane        (lat_lane),
        .size        (lat_size),
        .is_signed   (lat_signed),
        .store_data  (lat_wdata),
        .load_value  (load_value),
        .merged_word (merged_word)
    );

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state        <= IDLE;
            lat_lane     <= '0;
            lat_write    <= 1'b0;
            lat_size     <= SIZE_BYTE;
            lat_signed   <= 1'b0;
            lat_wdata    <= '0;
            RespValid    <= 1'b0;
            RespErr      <= 1'b0;
            RespRData    <= '0;
            MemAddress   <= '0;
            MemWriteData <= '0;
            MemWrite     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (ReqValid) begin
                        lat_lane   <= ReqAddr[1:0];
                        lat_write  <= ReqWrite;
                        lat_size   <= size_e'(ReqSize);
                        lat_signed <= ReqSigned;
                        lat_wdata  <= ReqWData[HALF_W-1:0];
                        MemAddress <= ReqAddr[ADDRESS_WIDTH+1:2];
                        RespRData  <= '0;
                        if (req_error(size_e'(ReqSize), ReqAddr[1:0])) begin
                            RespErr   <= 1'b1;
                            RespValid <= 1'b1;
                            state     <= RESP;
                        end else begin
                            RespErr <= 1'b0;
                            state   <= ACCESS;
                            // Word stores write straight away in ACCESS; no read needed.
                            if (ReqWrite && size_e'(ReqSize) == SIZE_WORD) begin
                                MemWrite     <= 1'b1;
                                MemWriteData <= ReqWData;
                            end
                        end
                    end
                end
                ACCESS: begin
                    MemWrite <= 1'b0;
                    if (!lat_write) begin
                        RespRData <= load_value;
                        RespValid <= 1'b1;
                        state     <= RESP;
                    end else if (lat_size == SIZE_WORD) begin
                        RespValid <= 1'b1;
                        state     <= RESP;
                    end else begin
                        // The write-data register doubles as the merge register.
                        MemWriteData <= merged_word;
                        MemWrite     <= 1'b1;
                        state        <= MERGE;
                    end
                end
                MERGE: begin
                    MemWrite  <= 1'b0;
                    RespValid <= 1'b1;
                    state     <= RESP;
                end
                RESP: begin
                    if (RespReady) begin
                        RespValid <= 1'b0;
                        RespErr   <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Randomized bench for load_store_unit with a byte-level reference model and a simple RAM.
module tb_load_store_unit;

    logic        Clk;
    logic        Rst_n;
    logic        ReqValid;
    logic        ReqReady;
    logic [17:0] ReqAddr;
    logic        ReqWrite;
    logic [1:0]  ReqSize;
    logic        ReqSigned;
    logic [31:0] ReqWData;
    logic        RespValid;
    logic        RespReady;
    logic [31:0] RespRData;
    logic        RespErr;
    logic [15:0] MemAddress;
    logic [31:0] MemWriteData;
    logic        MemWrite;
    logic [31:0] MemData;

    load_store_unit #(.ADDRESS_WIDTH(16), .DATA_WIDTH(32)) dut (
        .Clk(Clk), .Rst_n(Rst_n),
        .ReqValid(ReqValid), .ReqReady(ReqReady), .ReqAddr(ReqAddr), .ReqWrite(ReqWrite),
        .ReqSize(ReqSize), .ReqSigned(ReqSigned), .ReqWData(ReqWData),
        .RespValid(RespValid), .RespReady(RespReady), .RespRData(RespRData), .RespErr(RespErr),
        .MemAddress(MemAddress), .MemWriteData(MemWriteData), .MemWrite(MemWrite), .MemData(MemData)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // Environment RAM: combinational read, posedge write.
    logic [31:0] ram [0:65535];
    assign MemData = ram[MemAddress];
    always @(posedge Clk) if (MemWrite) ram[MemAddress] <= MemWriteData;

    logic [31:0] ref_mem [0:63];

    int checks = 0;
    int errors = 0;

    logic        pend = 1'b0;
    logic        seen;
    int          elapsed, wr_cnt, stall;
    logic [31:0] exp_data;
    logic        exp_err;
    int          exp_lat, exp_writes;
    logic [15:0] exp_w;
    logic [31:0] last_rdata;
    logic        last_err;
    int          last_lat;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    function automatic logic m_err(input logic [1:0] lo, input logic [1:0] sz);
        return (sz == 2'd3) || (sz == 2'd1 && (lo % 2) != 0) || (sz == 2'd2 && lo != 0);
    endfunction

    function automatic logic [31:0] m_load(input logic [31:0] w, input logic [1:0] lo,
                                           input logic [1:0] sz, input logic sg);
        int unsigned b [4];
        int unsigned v;
        for (int i = 0; i < 4; i++) b[i] = (w >> (8 * i)) & 32'hFF;
        v = 0;
        if (sz == 2'd0) begin
            v = b[lo];
            if (sg && v >= 128) v = v - 256;
        end else if (sz == 2'd1) begin
            v = b[lo] + 256 * b[lo + 1];
            if (sg && v >= 32768) v = v - 65536;
        end else if (sz == 2'd2) begin
            v = w;
        end
        return v;
    endfunction

    function automatic logic [31:0] m_store(input logic [31:0] w, input logic [1:0] lo,
                                            input logic [1:0] sz, input logic [31:0] d);
        int unsigned b [4];
        for (int i = 0; i < 4; i++) b[i] = (w >> (8 * i)) & 32'hFF;
        if (sz == 2'd2) return d;
        b[lo] = d & 32'hFF;
        if (sz == 2'd1) b[lo + 1] = (d >> 8) & 32'hFF;
        return b[0] + 256 * b[1] + 65536 * b[2] + 16777216 * b[3];
    endfunction

    // Called once per cycle at the falling edge; all DUT comparisons go through here.
    task automatic sample();
        if (pend) begin
            elapsed++;
            if (MemWrite) wr_cnt++;
            chk("busy_req_ready", ReqReady, 0);
            if (RespValid) begin
                if (!seen) begin
                    seen = 1'b1;
                    last_lat = elapsed;
                    chk("latency", elapsed, exp_lat);
                end
                chk("resp_rdata", RespRData, exp_data);
                chk("resp_err", RespErr, exp_err);
                if (RespReady) begin
                    chk("mem_writes", wr_cnt, exp_writes);
                    chk("ram_word", ram[exp_w], ref_mem[exp_w[5:0]]);
                    if (!exp_err) chk("mem_addr", MemAddress, exp_w);
                    last_rdata = RespRData;
                    last_err   = RespErr;
                    pend       = 1'b0;
                end else begin
                    stall++;
                end
            end
        end else begin
            chk("idle_resp_valid", RespValid, 0);
            chk("idle_mem_write", MemWrite, 0);
            chk("idle_req_ready", ReqReady, 1);
        end
    endtask

    task automatic tick();
        @(negedge Clk);
        sample();
        @(posedge Clk);
        #1;
    endtask

    task automatic do_req(input logic [17:0] a, input logic wr, input logic [1:0] sz,
                          input logic sg, input logic [31:0] d, input int hold);
        logic [31:0] old;
        exp_w      = {10'd0, a[7:2]};
        old        = ref_mem[a[7:2]];
        exp_err    = m_err(a[1:0], sz);
        exp_data   = (exp_err || wr) ? 32'd0 : m_load(old, a[1:0], sz, sg);
        exp_lat    = exp_err ? 1 : ((wr && sz != 2'd2) ? 3 : 2);
        exp_writes = (!exp_err && wr) ? 1 : 0;
        if (!exp_err && wr) ref_mem[a[7:2]] = m_store(old, a[1:0], sz, d);
        ReqAddr = a; ReqWrite = wr; ReqSize = sz; ReqSigned = sg; ReqWData = d;
        ReqValid = 1'b1;
        tick();
        ReqValid = 1'b0;
        pend = 1'b1; seen = 1'b0; elapsed = 0; wr_cnt = 0; stall = 0;
        for (int k = 0; k < 40 && pend; k++) begin
            RespReady = (hold == 0) || (seen && stall >= hold);
            tick();
        end
        RespReady = 1'b0;
        chk("resp_timeout", pend, 0);
        pend = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        Rst_n = 1'b0; ReqValid = 1'b0; ReqAddr = '0; ReqWrite = 1'b0; ReqSize = 2'd0;
        ReqSigned = 1'b0; ReqWData = '0; RespReady = 1'b0;
        #12;
        chk("rst_resp_valid", RespValid, 0);
        chk("rst_resp_err", RespErr, 0);
        chk("rst_mem_write", MemWrite, 0);
        chk("rst_rdata", RespRData, 0);
        chk("rst_mem_addr", MemAddress, 0);
        chk("rst_mem_wdata", MemWriteData, 0);
        chk("rst_req_ready", ReqReady, 1);
        @(posedge Clk); #1;
        Rst_n = 1'b1;

        // Model pins against hand-computed values.
        chk("pin_lb_s", m_load(32'h80FF7F01, 2'd3, 2'd0, 1'b1), 32'hFFFFFF80);
        chk("pin_lb_u", m_load(32'h80FF7F01, 2'd3, 2'd0, 1'b0), 32'h00000080);
        chk("pin_lh_s", m_load(32'h80FF7F01, 2'd2, 2'd1, 1'b1), 32'hFFFF80FF);
        chk("pin_sb", m_store(32'h11223344, 2'd1, 2'd0, 32'h000000AA), 32'h1122AA44);
        chk("pin_sh", m_store(32'h11223344, 2'd2, 2'd1, 32'h0000BEEF), 32'hBEEF3344);
        chk("pin_err_w", {31'd0, m_err(2'd2, 2'd2)}, 1);

        for (int i = 0; i < 64; i++) do_req({10'd0, 6'(i), 2'd0}, 1'b1, 2'd2, 1'b0, $urandom, 0);

        do_req(18'h10, 1'b1, 2'd2, 1'b0, 32'hDEADBEEF, 0);
        chk("sw_ram", ram[4], 32'hDEADBEEF);
        do_req(18'h10, 1'b0, 2'd2, 1'b0, 32'h0, 0);
        chk("lw_lit", last_rdata, 32'hDEADBEEF);
        chk("lw_lat", last_lat, 2);

        do_req(18'h10, 1'b1, 2'd2, 1'b0, 32'h80FF7F01, 0);
        do_req(18'h13, 1'b0, 2'd0, 1'b1, 32'h0, 0);
        chk("lb_s_lit", last_rdata, 32'hFFFFFF80);
        do_req(18'h13, 1'b0, 2'd0, 1'b0, 32'h0, 1);
        chk("lb_u_lit", last_rdata, 32'h00000080);
        do_req(18'h12, 1'b0, 2'd1, 1'b1, 32'h0, 2);
        chk("lh_s_lit", last_rdata, 32'hFFFF80FF);

        do_req(18'h10, 1'b1, 2'd2, 1'b0, 32'h11223344, 0);
        do_req(18'h11, 1'b1, 2'd0, 1'b0, 32'h123456AA, 0);
        chk("sb_ram_lit", ram[4], 32'h1122AA44);
        chk("sb_lat", last_lat, 3);
        do_req(18'h10, 1'b1, 2'd2, 1'b0, 32'h11223344, 0);
        do_req(18'h12, 1'b1, 2'd1, 1'b0, 32'h5555BEEF, 0);
        chk("sh_ram_lit", ram[4], 32'hBEEF3344);

        do_req(18'h02, 1'b0, 2'd2, 1'b0, 32'h0, 0);
        chk("err_w_lit", last_err, 1);
        chk("err_w_lat", last_lat, 1);
        do_req(18'h01, 1'b1, 2'd1, 1'b0, 32'hFFFF, 0);
        chk("err_h_lit", last_err, 1);
        do_req(18'h10, 1'b1, 2'd3, 1'b0, 32'hFFFFFFFF, 0);
        chk("err_sz_lit", last_err, 1);
        chk("err_sz_rdata", last_rdata, 0);

        do_req(18'h10, 1'b0, 2'd2, 1'b0, 32'h0, 5);
        chk("bp_stall", stall, 5);

        // Abort a byte store during its merge cycle.
        do_req(18'h10, 1'b1, 2'd2, 1'b0, 32'h11223344, 0);
        ReqAddr = 18'h11; ReqWrite = 1'b1; ReqSize = 2'd0; ReqSigned = 1'b0; ReqWData = 32'hAA;
        ReqValid = 1'b1;
        tick();
        ReqValid = 1'b0;
        @(posedge Clk); #1;
        chk("merge_mem_write", MemWrite, 1);
        chk("merge_wdata", MemWriteData, 32'h1122AA44);
        #2 Rst_n = 1'b0;
        #1;
        chk("abort_mem_write", MemWrite, 0);
        chk("abort_resp_valid", RespValid, 0);
        chk("abort_rdata", RespRData, 0);
        chk("abort_mem_addr", MemAddress, 0);
        chk("abort_mem_wdata", MemWriteData, 0);
        repeat (2) @(posedge Clk);
        #1;
        chk("abort_ram", ram[4], 32'h11223344);
        Rst_n = 1'b1;
        chk("abort_req_ready", ReqReady, 1);
        tick();
        do_req(18'h10, 1'b0, 2'd2, 1'b0, 32'h0, 0);
        chk("abort_reload", last_rdata, 32'h11223344);

        for (int n = 0; n < 300; n++) begin
            int unsigned r;
            logic [1:0]  sz;
            r  = $urandom_range(0, 9);
            sz = (r < 3) ? 2'd0 : (r < 6) ? 2'd1 : (r < 9) ? 2'd2 : 2'd3;
            do_req({10'd0, 6'($urandom_range(0, 63)), 2'($urandom_range(0, 3))},
                   1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)), $urandom,
                   ($urandom_range(0, 7) == 0) ? 5 : int'($urandom_range(0, 2)));
        end
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
